kc705_status_monitor: RTL and testbench
=======================================

# kc705_status_monitor

Parametrised board-status monitor for KC705 bring-up designs: qualifies N asynchronous ready/lock inputs (MMCM locked, DDR calibration done, PCIe link up, …) into a stable `all_ready`, records lock-loss events per channel, and drives a mode-selectable LED bank with heartbeat and fault blink. It sits at the top level beside the clocking/reset logic and is the single source of the "system ready" qualifier and of the front-panel LEDs.

## Interface
- `NUM_CH`, 4: monitored channels; 1..`LED_W`-1.
- `LED_W`, 8: LED bank width.
- `HB_W`, 28: heartbeat counter width.
- `HB_BIT`, 26: heartbeat bit of the counter; ≥2, < `HB_W`.
- `STABLE_CYC`, 1024: cycles all channels must be continuously high before `all_ready`; ≥2.
- `CNT_W`, 8: per-channel loss counter width.

- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  asynchronous, active-low reset.
- `status_in`  in  `NUM_CH`  raw ready/lock bits, asynchronous to `clk`.
- `clear_sticky`  in  1  one-cycle pulse: clears sticky flags, counters, FAULT.
- `led_mode`  in  2  LED display select (quasi-static).
- `ready_vec`  out  `NUM_CH`  synchronised `status_in`.
- `all_ready`  out  1  qualified system-ready.
- `loss_sticky`  out  `NUM_CH`  channel has fallen since last clear.
- `loss_cnt`  out  `NUM_CH*CNT_W`  saturating fall counts, channel i at [i*CNT_W +: CNT_W].
- `fault`  out  1  FSM in FAULT.
- `heartbeat`  out  1  counter bit `HB_BIT`.
- `leds`  out  `LED_W`  LED drive, active-high.

## Operation
- Reset: every output, synchroniser flop, counter and FSM state cleared to 0/WAIT.
- Synchroniser: two flops per channel; `ready_vec` is second stage. Previous-value register per channel for fall detection.
- Fall on channel i (`ready_vec[i]` 1→0): `loss_sticky[i]`←1, `loss_cnt` i increments, saturating at 2^`CNT_W`-1.
- `clear_sticky` same cycle as a fall on channel i: fall wins for that channel (sticky=1, count=1); other channels clear.
- FSM (registered, `all_ready`=1 only in READY):
  - WAIT: all `ready_vec` high → QUALIFY, qualify counter←0.
  - QUALIFY: any low → WAIT; counter reaches `STABLE_CYC`-1 → READY; else count.
  - READY: any low → FAULT.
  - FAULT: `clear_sticky` with all high → QUALIFY (counter←0); with any low → WAIT; else hold.
- Heartbeat counter free-runs, wraps at 2^`HB_W`; blink = counter bit `HB_BIT`-2.
- `leds[LED_W-1]` = blink in FAULT, else heartbeat. Lower bits by `led_mode`:
  - 0: `ready_vec`, zero-extended.
  - 1: `loss_sticky`, zero-extended.
  - 2: channel-0 `loss_cnt`, truncated/zero-extended to `LED_W`-1.
  - 3: all `LED_W`-1 bits = blink (lamp test).

## Timing
- `status_in` → `ready_vec`: 2 cycles.
- `ready_vec` fall → `loss_sticky`/`loss_cnt`: +1 cycle.
- `ready_vec` all high → `all_ready`: `STABLE_CYC`+1 cycles (WAIT→QUALIFY 1, count `STABLE_CYC`); drop → `all_ready` low next cycle.
- `leds`, `fault`, `heartbeat` registered; 1-cycle latency from source state.
- `rst_n` assertion mid-QUALIFY/READY: immediate return to reset values; no loss recorded on release.

## Configuration
- `KC705_STATUS_MON_LOSS_CNT_EN` defined: per-channel loss counters built as above.
- Not defined: counters omitted, `loss_cnt` tied 0, mode 2 shows 0; sticky flags, FSM, LEDs unchanged.

## Structure
- Shared package `kc705_status_pkg`: FSM state encoding (WAIT, QUALIFY, READY, FAULT), LED mode constants, qualify-counter width function (clog2 of `STABLE_CYC`).
- One sub-module: `kc705_status_chan` (synchroniser, fall detect, sticky, optional counter), generated `NUM_CH` times; FSM, heartbeat and LED mux in top.

## Test plan
- Reset then `status_in`=4'hF at t0, `STABLE_CYC`=16 → `all_ready` rises exactly 19 cycles after t0 (2 sync + 1 + 16), `leds[3:0]`=4'hF in mode 0.
- Channel 2 drops for 1 cycle during QUALIFY → FSM back to WAIT, `loss_sticky`=4'b0100, `loss_cnt` ch2=1, requalification restarts full 16.
- Channel 0 drops in READY → `all_ready` 0 and `fault` 1 within 4 cycles; `leds[7]` follows bit `HB_BIT`-2; `clear_sticky` while all high → QUALIFY, sticky/counts 0.
- 300 falls on channel 1 with `CNT_W`=8 → count saturates at 255; fall coincident with `clear_sticky` → count 1, sticky 1.
- `led_mode` 0..3 cycling with `loss_sticky`=4'b1010 → `leds[6:0]` = ready_vec, 7'h0A, ch0 count, 7'h7F/0 blinking.
- Build without `KC705_STATUS_MON_LOSS_CNT_EN`: repeat fall test → `loss_cnt` stays 0, sticky and FSM identical.

Source files
------------

// File: rtl/kc705_status_pkg.sv
// Purpose: shared types/constants for the KC705 board-status monitor.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: FSM state encoding, LED display-mode codes, qualify-counter width helper.
package kc705_status_pkg;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_READY   = 2'd2,
    ST_FAULT   = 2'd3
  } mon_state_e;

  localparam logic [1:0] LED_MODE_READY  = 2'd0;
  localparam logic [1:0] LED_MODE_STICKY = 2'd1;
  localparam logic [1:0] LED_MODE_CNT0   = 2'd2;
  localparam logic [1:0] LED_MODE_LAMP   = 2'd3;

  // Qualify counter only has to reach stable_cyc-1, so clog2(stable_cyc) bits suffice.
  function automatic int qual_cnt_w(input int stable_cyc);
    return (stable_cyc < 2) ? 1 : $clog2(stable_cyc);
  endfunction

endpackage

// File: rtl/kc705_status_chan.sv
// Purpose: one monitored channel - 2-flop synchroniser, fall detect, sticky loss flag, loss counter.
// Latency: status_i -> ready_o 2 cycles; ready_o fall -> sticky_o/cnt_o +1 cycle.
// Backpressure: none; every fall is recorded.
// Ports: clk, rst_n (async active-low), status_i (async raw bit), clear_i (sticky/count clear pulse),
//        ready_o (synchronised bit), sticky_o (fell since last clear), cnt_o (saturating fall count).
// Config: KC705_STATUS_MON_LOSS_CNT_EN builds the counter; otherwise cnt_o is tied to zero.
module kc705_status_chan
  import kc705_status_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             status_i,
  input  logic             clear_i,
  output logic             ready_o,
  output logic             sticky_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic sync1_q, sync2_q, prev_q, sticky_q;
  logic fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= status_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // prev_q resets low, so channels already high at reset release never log a loss.
  assign fall = prev_q & ~sync2_q;

  // A fall in the same cycle as a clear wins: the event must not be lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (fall) begin
      sticky_q <= 1'b1;
    end else if (clear_i) begin
      sticky_q <= 1'b0;
    end
  end

`ifdef KC705_STATUS_MON_LOSS_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (fall) begin
      if (clear_i) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (clear_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`else
  assign cnt_o = '0;
`endif

  assign ready_o  = sync2_q;
  assign sticky_o = sticky_q;

endmodule

// File: rtl/kc705_status_monitor.sv
// Purpose: KC705 board-status monitor - qualified all_ready, per-channel loss tracking, LED bank.
// Latency: status_in -> ready_vec 2; all high -> all_ready STABLE_CYC+1; leds/fault/heartbeat 1 after source.
// Backpressure: none; purely observational block.
// Ports: clk, rst_n (async active-low), status_in (raw async bits), clear_sticky (pulse),
//        led_mode (display select), ready_vec, all_ready, loss_sticky, loss_cnt, fault, heartbeat, leds.
// Config: define KC705_STATUS_MON_LOSS_CNT_EN to build per-channel loss counters (else loss_cnt = 0).
module kc705_status_monitor
  import kc705_status_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int LED_W      = 8,
  parameter int HB_W       = 28,
  parameter int HB_BIT     = 26,
  parameter int STABLE_CYC = 1024,
  parameter int CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       status_in,
  input  logic                    clear_sticky,
  input  logic [1:0]              led_mode,
  output logic [NUM_CH-1:0]       ready_vec,
  output logic                    all_ready,
  output logic [NUM_CH-1:0]       loss_sticky,
  output logic [NUM_CH*CNT_W-1:0] loss_cnt,
  output logic                    fault,
  output logic                    heartbeat,
  output logic [LED_W-1:0]        leds
);

  localparam int QW    = qual_cnt_w(STABLE_CYC);
  localparam int LOW_W = LED_W - 1;
  localparam int C0_W  = (CNT_W < LOW_W) ? CNT_W : LOW_W;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    kc705_status_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .status_i (status_in[g]),
      .clear_i  (clear_sticky),
      .ready_o  (ready_vec[g]),
      .sticky_o (loss_sticky[g]),
      .cnt_o    (loss_cnt[g*CNT_W +: CNT_W])
    );
  end

  logic all_high;
  assign all_high = &ready_vec;

  // ---------------- qualification FSM ----------------
  mon_state_e    state_q;
  logic [QW-1:0] qcnt_q;
  logic          fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT;
      qcnt_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= (state_q == ST_FAULT);
      case (state_q)
        ST_WAIT: begin
          if (all_high) begin
            state_q <= ST_QUALIFY;
            qcnt_q  <= '0;
          end
        end
        ST_QUALIFY: begin
          if (!all_high) begin
            state_q <= ST_WAIT;
          end else if (qcnt_q == QW'(STABLE_CYC - 1)) begin
            state_q <= ST_READY;
          end else begin
            qcnt_q <= qcnt_q + 1'b1;
          end
        end
        ST_READY: begin
          if (!all_high) begin
            state_q <= ST_FAULT;
          end
        end
        ST_FAULT: begin
          // Leaving FAULT needs an operator acknowledge; a still-low channel goes back to WAIT.
          if (clear_sticky) begin
            if (all_high) begin
              state_q <= ST_QUALIFY;
              qcnt_q  <= '0;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        default: state_q <= ST_WAIT;
      endcase
    end
  end

  assign all_ready = (state_q == ST_READY);
  assign fault     = fault_q;

  // ---------------- heartbeat and LEDs ----------------
  logic [HB_W-1:0] hb_q;
  logic            heartbeat_q;
  logic            blink;
  logic [LED_W-1:0] leds_q;
  logic [LOW_W-1:0] led_low_d;
  logic            hb_unused;

  assign blink     = hb_q[HB_BIT-2];
  assign hb_unused = ^hb_q;

  always_comb begin
    led_low_d = '0;
    case (led_mode)
      LED_MODE_READY: begin
        for (int i = 0; i < NUM_CH; i++) led_low_d[i] = ready_vec[i];
      end
      LED_MODE_STICKY: begin
        for (int i = 0; i < NUM_CH; i++) led_low_d[i] = loss_sticky[i];
      end
      LED_MODE_CNT0: begin
        for (int i = 0; i < C0_W; i++) led_low_d[i] = loss_cnt[i];
      end
      default: led_low_d = {LOW_W{blink}};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_q        <= '0;
      heartbeat_q <= 1'b0;
      leds_q      <= '0;
    end else begin
      hb_q        <= hb_q + 1'b1;
      heartbeat_q <= hb_q[HB_BIT];
      leds_q      <= {((state_q == ST_FAULT) ? blink : hb_q[HB_BIT]), led_low_d};
    end
  end

  assign heartbeat = heartbeat_q;
  assign leds      = leds_q;

endmodule

// File: tb/tb_kc705_status_monitor.sv
// Purpose: self-checking bench for kc705_status_monitor (small heartbeat and STABLE_CYC=16).
// Latency: n/a.
// Backpressure: n/a.
module tb_kc705_status_monitor;

  localparam int NUM_CH = 4, LED_W = 8, HB_W = 8, HB_BIT = 4, STABLE_CYC = 16, CNT_W = 8;
`ifdef KC705_STATUS_MON_LOSS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  status_in = 4'h0;
  logic        clear_sticky = 1'b0;
  logic [1:0]  led_mode = 2'd0;
  logic [3:0]  ready_vec;
  logic        all_ready;
  logic [3:0]  loss_sticky;
  logic [31:0] loss_cnt;
  logic        fault;
  logic        heartbeat;
  logic [7:0]  leds;

  kc705_status_monitor #(
    .NUM_CH(NUM_CH), .LED_W(LED_W), .HB_W(HB_W), .HB_BIT(HB_BIT),
    .STABLE_CYC(STABLE_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .status_in(status_in), .clear_sticky(clear_sticky),
    .led_mode(led_mode), .ready_vec(ready_vec), .all_ready(all_ready),
    .loss_sticky(loss_sticky), .loss_cnt(loss_cnt), .fault(fault),
    .heartbeat(heartbeat), .leds(leds)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release: the heartbeat counter value.
  int unsigned ecnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] cexp(input logic [7:0] c3, input logic [7:0] c2,
                                       input logic [7:0] c1, input logic [7:0] c0);
    return CNT_EN ? {c3, c2, c1, c0} : 32'h0;
  endfunction

  // heartbeat = counter bit 4 one edge ago; leds[7] = bit 2 in FAULT, else bit 4.
  task automatic chk_hb(input string name, input logic exp_fault);
    logic [31:0] km1;
    km1 = (ecnt == 0) ? 32'h0 : 32'(ecnt - 1);
    chk({name, "_hb"}, 32'(heartbeat), 32'(km1[4]));
    chk({name, "_led7"}, 32'(leds[7]), 32'(exp_fault ? km1[2] : km1[4]));
  endtask

  typedef struct {
    logic [3:0] st;      // status applied
    bit         keep;    // hold st, else one-cycle pulse then 4'hF
    logic [1:0] mode;
    logic [3:0] rv;
    logic [3:0] sticky;
    logic [7:0] c3, c2, c1, c0;
    logic [6:0] low;     // leds[6:0] expected (mode 2 derived from c0)
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [31:0] km1;
    logic [6:0]  exp_low;

    tbl[0] = '{4'hF, 1'b0, 2'd0, 4'hF, 4'b0010, 8'd0, 8'd0, 8'd1, 8'd0, 7'h0F};
    tbl[1] = '{4'h7, 1'b0, 2'd1, 4'hF, 4'b1010, 8'd1, 8'd0, 8'd1, 8'd0, 7'h0A};
    tbl[2] = '{4'hF, 1'b0, 2'd2, 4'hF, 4'b1010, 8'd1, 8'd0, 8'd1, 8'd0, 7'h00};
    tbl[3] = '{4'hE, 1'b0, 2'd2, 4'hF, 4'b1011, 8'd1, 8'd0, 8'd1, 8'd1, 7'h00};
    tbl[4] = '{4'hE, 1'b0, 2'd2, 4'hF, 4'b1011, 8'd1, 8'd0, 8'd1, 8'd2, 7'h00};
    tbl[5] = '{4'hF, 1'b0, 2'd1, 4'hF, 4'b1011, 8'd1, 8'd0, 8'd1, 8'd2, 7'h0B};
    tbl[6] = '{4'hF, 1'b0, 2'd0, 4'hF, 4'b1011, 8'd1, 8'd0, 8'd1, 8'd2, 7'h0F};
    tbl[7] = '{4'h5, 1'b0, 2'd0, 4'hF, 4'b1011, 8'd2, 8'd0, 8'd2, 8'd2, 7'h0F};
    tbl[8] = '{4'h3, 1'b1, 2'd0, 4'h3, 4'b1111, 8'd3, 8'd1, 8'd2, 8'd2, 7'h03};
    tbl[9] = '{4'hF, 1'b1, 2'd1, 4'hF, 4'b1111, 8'd3, 8'd1, 8'd2, 8'd2, 7'h0F};

    // ---- reset state ----
    tick(2);
    chk("rst_rv", 32'(ready_vec), 32'h0);
    chk("rst_rdy", 32'(all_ready), 32'h0);
    chk("rst_sticky", 32'(loss_sticky), 32'h0);
    chk("rst_cnt", loss_cnt, 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_leds", 32'(leds), 32'h0);
    chk_hb("rst", 1'b0);

    // ---- qualification from reset: all_ready exactly 19 cycles after status ----
    rst_n = 1'b1;
    status_in = 4'hF;
    tick(18);
    chk("qual_early", 32'(all_ready), 32'h0);
    tick(1);
    chk("qual_rise", 32'(all_ready), 32'h1);
    chk("qual_leds", 32'(leds[6:0]), 32'h0F);
    chk("qual_fault", 32'(fault), 32'h0);
    chk_hb("qual", 1'b0);

    // ---- reset while READY: immediate clear, no loss on release ----
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", 32'(all_ready), 32'h0);
    chk("mid_rst_rv", 32'(ready_vec), 32'h0);
    chk("mid_rst_leds", 32'(leds), 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(8);
    chk("rel_sticky", 32'(loss_sticky), 32'h0);
    chk("rel_cnt", loss_cnt, 32'h0);
    chk("rel_rdy", 32'(all_ready), 32'h0);

    // ---- channel 2 glitch during QUALIFY: full 16-cycle requalification ----
    status_in = 4'hB;
    tick(1);
    status_in = 4'hF;
    tick(2);
    chk("glitch_sticky", 32'(loss_sticky), 32'h4);
    chk("glitch_cnt", loss_cnt, cexp(8'd0, 8'd1, 8'd0, 8'd0));
    tick(16);
    chk("requal_early", 32'(all_ready), 32'h0);
    tick(1);
    chk("requal_rise", 32'(all_ready), 32'h1);

    // ---- channel 0 drop in READY -> FAULT ----
    status_in = 4'hE;
    tick(3);
    chk("drop_rdy", 32'(all_ready), 32'h0);
    chk("drop_fault_lat", 32'(fault), 32'h0);
    status_in = 4'hF;
    tick(1);
    chk("drop_fault", 32'(fault), 32'h1);
    chk("drop_sticky", 32'(loss_sticky), 32'h5);
    chk("drop_cnt", loss_cnt, cexp(8'd0, 8'd1, 8'd0, 8'd1));
    for (int i = 0; i < 16; i++) begin
      tick(1);
      chk($sformatf("fault_hold%0d", i), 32'(fault), 32'h1);
      chk_hb($sformatf("fault_blink%0d", i), 1'b1);
    end
    clear_sticky = 1'b1;
    tick(1);
    clear_sticky = 1'b0;
    chk("clr_sticky", 32'(loss_sticky), 32'h0);
    chk("clr_cnt", loss_cnt, 32'h0);
    chk("clr_fault_lat", 32'(fault), 32'h1);
    tick(1);
    chk("clr_fault", 32'(fault), 32'h0);
    tick(14);
    chk("clr_requal_early", 32'(all_ready), 32'h0);
    tick(1);
    chk("clr_requal_rise", 32'(all_ready), 32'h1);

    // ---- 300 falls on channel 1: saturation ----
    for (int i = 0; i < 300; i++) begin
      status_in = 4'hD;
      tick(1);
      status_in = 4'hF;
      tick(1);
    end
    tick(4);
    chk("sat_cnt", loss_cnt, cexp(8'd0, 8'd0, 8'd255, 8'd0));
    chk("sat_sticky", 32'(loss_sticky), 32'h2);
    chk("sat_fault", 32'(fault), 32'h1);
    chk("sat_rdy", 32'(all_ready), 32'h0);

    // ---- fall coincident with clear: fall wins on channel 1 ----
    status_in = 4'hD;
    tick(1);
    status_in = 4'hF;
    tick(1);
    clear_sticky = 1'b1;
    tick(1);
    clear_sticky = 1'b0;
    chk("coinc_sticky", 32'(loss_sticky), 32'h2);
    chk("coinc_cnt", loss_cnt, cexp(8'd0, 8'd0, 8'd1, 8'd0));
    tick(1);
    chk("coinc_fault", 32'(fault), 32'h0);

    // ---- table: LED modes and accumulated loss state ----
    for (int i = 0; i < 10; i++) begin
      status_in = tbl[i].st;
      led_mode  = tbl[i].mode;
      tick(1);
      if (!tbl[i].keep) status_in = 4'hF;
      tick(4);
      exp_low = (tbl[i].mode == 2'd2) ? (CNT_EN ? tbl[i].c0[6:0] : 7'h0) : tbl[i].low;
      chk($sformatf("v%0d_rv", i), 32'(ready_vec), 32'(tbl[i].rv));
      chk($sformatf("v%0d_sticky", i), 32'(loss_sticky), 32'(tbl[i].sticky));
      chk($sformatf("v%0d_cnt", i), loss_cnt, cexp(tbl[i].c3, tbl[i].c2, tbl[i].c1, tbl[i].c0));
      chk($sformatf("v%0d_low", i), 32'(leds[6:0]), 32'(exp_low));
    end

    // ---- lamp test: all low LEDs follow blink ----
    led_mode = 2'd3;
    tick(1);
    for (int i = 0; i < 16; i++) begin
      tick(1);
      km1 = 32'(ecnt - 1);
      chk($sformatf("lamp%0d", i), 32'(leds[6:0]), km1[2] ? 32'h7F : 32'h0);
      chk_hb($sformatf("lamp%0d", i), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
